digital_lock_fsm_param: RTL and testbench
=========================================

// Module: digital_lock_fsm_param
// PURPOSE
//  Parametrised keypad lock controller: NUM_KEYS keys, CODE_LEN-digit code.
//  Adds a failed-attempt counter, timed lockout, entry timeout, auto-relock and status LED/RGB drive.
//  Sits after per-key debounce + single-pulse logic; slow-time base is an external tick (e.g. 25 Hz pulse_gen).
// PARAMETERS
//  NUM_KEYS       4      number of keys; KEY_W = $clog2(NUM_KEYS) (localparam, min 1)
//  CODE_LEN       4      digits per code
//  DEFAULT_CODE   8'h84  reset code, CODE_LEN*KEY_W bits, first digit in MSBs (keys 2,0,1,0)
//  MAX_FAILS      3      consecutive mismatches that trigger LOCKOUT (>=1)
//  LOCKOUT_TICKS  250    ticks spent in LOCKOUT
//  ERR_TICKS      25     ticks spent in ERROR
//  ENTRY_TICKS    125    ticks without a key that abandon an entry
//  UNLOCK_TICKS   250    ticks before auto-relock; 0 disables auto-relock
// PORTS
//  clk        in   1                clock
//  rst_n      in   1                async active-low reset
//  tick       in   1                one-cycle time-base pulse
//  key_pulse  in   NUM_KEYS         one-cycle key-press pulses (already debounced)
//  lock_req   in   1                pulse: relock from UNLOCKED
//  set_code   in   1                pulse: enter SETCODE from UNLOCKED (only with macro)
//  unlocked   out  1                high in UNLOCKED
//  locked_out out  1                high in LOCKOUT
//  fail_cnt   out  $clog2(MAX_FAILS+1)  consecutive-failure count
//  led        out  CODE_LEN         progress bar: bit i set when more than i digits are held
//  rgb        out  3                {r,g,b} status
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; code reg=DEFAULT_CODE; all counters 0.
//  - Reset outputs: unlocked=0, locked_out=0, fail_cnt=0, led=0, rgb=0, blink phase=0.
//  - Reset wins at any point, including mid-entry or mid-SETCODE.
//  - Key event: any key_pulse bit high. Digit = index of the set bit.
//  - More than one bit set in the same cycle is an invalid digit: it is counted and always mismatches.
//  - States: IDLE, ENTRY, UNLOCKED, ERROR, LOCKOUT, SETCODE (macro only). Registered outputs, 1-cycle latency.
//  - IDLE: key event -> ENTRY with digit_cnt=1.
//  - ENTRY: each key event stores its digit and increments digit_cnt.
//  - Digit k is compared with code[(CODE_LEN-k)*KEY_W-1 -: KEY_W]. A mismatch sets a sticky bad flag; entry does not abort early.
//  - On the CODE_LEN-th digit (cycle t), decision at t+1:
//    - bad=0: UNLOCKED, fail_cnt cleared.
//    - bad=1: fail_cnt+1; state LOCKOUT if the new count equals MAX_FAILS, else ERROR.
//  - ENTRY timeout: ENTRY_TICKS ticks with no key -> IDLE, digits dropped, fail_cnt unchanged.
//  - tick and key in the same cycle: the key restarts the timeout count.
//  - UNLOCKED: keys ignored. lock_req, or UNLOCK_TICKS ticks (if nonzero) -> IDLE.
//  - lock_req and set_code in the same cycle: lock_req wins.
//  - ERROR: keys ignored for ERR_TICKS ticks -> IDLE.
//  - LOCKOUT: keys ignored for LOCKOUT_TICKS ticks -> IDLE, fail_cnt cleared.
//  - Tick counter clears on every state entry; its width covers the largest *_TICKS value.
//  - digit_cnt is never more than CODE_LEN. led = (1<<digit_cnt)-1 in ENTRY/SETCODE, else 0.
//  - Blink phase toggles on each tick.
//  - rgb by state: IDLE 000; ENTRY 001; UNLOCKED 010; ERROR 100; LOCKOUT {blink,0,0}; SETCODE {0,1,blink}.
// CONFIGURATION
//  - Macro DIGITAL_LOCK_CODE_CHANGE_EN defined:
//    - set_code pulse in UNLOCKED -> SETCODE.
//    - Next CODE_LEN key events (each must be single-key) are shifted into a shadow reg.
//    - After the last digit the shadow reg is copied into the code reg and state returns to UNLOCKED.
//    - A multi-key event, lock_req or ENTRY_TICKS idle ticks aborts: code unchanged, state -> IDLE.
//  - Macro undefined: set_code ignored, no SETCODE state, code fixed at DEFAULT_CODE (constant, no reg).
// TESTING
//  1 Defaults; keys 2,0,1,0 -> unlocked=1 one cycle after 4th pulse; rgb=010; fail_cnt=0.
//  2 Keys 2,0,1,1 -> ERROR, rgb=100, fail_cnt=1; after 25 ticks -> IDLE.
//  3 Three wrong codes -> locked_out=1, fail_cnt=3, red blinks per tick.
//    Correct code during lockout is ignored; after 250 ticks -> IDLE, fail_cnt=0.
//  4 Keys 2,0 then 125 ticks idle -> IDLE, led=0, fail_cnt unchanged.
//    Keys {0,1} pressed together mid-code -> mismatch.
//  5 Unlock, then 250 ticks -> relock. Unlock, then lock_req -> IDLE next cycle.
//    rst_n low mid-entry -> all outputs 0.
//  6 With DIGITAL_LOCK_CODE_CHANGE_EN: unlock, set_code, keys 3,3,1,0 -> UNLOCKED; lock_req.
//    Then 3,3,1,0 unlocks and 2,0,1,0 fails.
//    Without the macro: set_code ignored and 2,0,1,0 still unlocks.

Source files
------------

// File: rtl/digital_lock_fsm_param_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// digital_lock_fsm_param_if: control/status bundle of the keypad lock.  Rev 1.0
// ----------------------------------------------------------------------------
interface digital_lock_fsm_param_if #(
  parameter int NUM_KEYS  = 4,
  parameter int CODE_LEN  = 4,
  parameter int MAX_FAILS = 3
);
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);

  logic                tick_i;
  logic [NUM_KEYS-1:0] key_pulse_i;
  logic                lock_req_i;
  logic                set_code_i;
  logic                unlocked_o;
  logic                locked_out_o;
  logic [FAIL_W-1:0]   fail_cnt_o;
  logic [CODE_LEN-1:0] led_o;
  logic [2:0]          rgb_o;

  modport master (
    output tick_i, key_pulse_i, lock_req_i, set_code_i,
    input  unlocked_o, locked_out_o, fail_cnt_o, led_o, rgb_o
  );

  modport slave (
    input  tick_i, key_pulse_i, lock_req_i, set_code_i,
    output unlocked_o, locked_out_o, fail_cnt_o, led_o, rgb_o
  );
endinterface
`default_nettype wire

// File: rtl/digital_lock_fsm_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// digital_lock_fsm_param: keypad lock FSM; DIGITAL_LOCK_CODE_CHANGE_EN adds code change.
// Rev 1.0
// ----------------------------------------------------------------------------
module digital_lock_fsm_param #(
  parameter int NUM_KEYS      = 4,
  parameter int CODE_LEN      = 4,
  parameter logic [CODE_LEN*((NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1)-1:0] DEFAULT_CODE = 8'h84,
  parameter int MAX_FAILS     = 3,
  parameter int LOCKOUT_TICKS = 250,
  parameter int ERR_TICKS     = 25,
  parameter int ENTRY_TICKS   = 125,
  parameter int UNLOCK_TICKS  = 250
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  digital_lock_fsm_param_if.slave bus
);
  localparam int KEY_W  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int CODE_W = CODE_LEN * KEY_W;
  localparam int CNT_W  = $clog2(CODE_LEN + 1);
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int MAX_T1 = (LOCKOUT_TICKS > ERR_TICKS) ? LOCKOUT_TICKS : ERR_TICKS;
  localparam int MAX_T2 = (ENTRY_TICKS > UNLOCK_TICKS) ? ENTRY_TICKS : UNLOCK_TICKS;
  localparam int MAX_T  = (MAX_T1 > MAX_T2) ? MAX_T1 : MAX_T2;
  localparam int TICK_W = $clog2(MAX_T + 1);
  localparam logic [TICK_W-1:0] LOCK_LAST   = TICK_W'(LOCKOUT_TICKS - 1);
  localparam logic [TICK_W-1:0] ERR_LAST    = TICK_W'(ERR_TICKS - 1);
  localparam logic [TICK_W-1:0] ENTRY_LAST  = TICK_W'(ENTRY_TICKS - 1);
  localparam logic [TICK_W-1:0] UNLOCK_LAST = TICK_W'((UNLOCK_TICKS > 0) ? UNLOCK_TICKS - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ENTRY    = 3'd1,
    S_UNLOCKED = 3'd2,
    S_ERROR    = 3'd3,
`ifdef DIGITAL_LOCK_CODE_CHANGE_EN
    S_LOCKOUT  = 3'd4,
    S_SETCODE  = 3'd5
`else
    S_LOCKOUT  = 3'd4
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    digit_cnt_q, digit_cnt_d;
  logic                bad_q, bad_d;
  logic [FAIL_W-1:0]   fail_cnt_q, fail_cnt_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic                blink_q, blink_d;
  logic                unlocked_q, unlocked_d;
  logic                locked_out_q, locked_out_d;
  logic [CODE_LEN-1:0] led_q, led_d;
  logic [2:0]          rgb_q, rgb_d;
  logic [CODE_W-1:0]   w_code;
  logic [KEY_W-1:0]    w_digit, w_exp_digit;
  logic                w_key, w_multi, w_match, w_last, w_in_entry;
  logic [FAIL_W-1:0]   w_fail_inc;

`ifdef DIGITAL_LOCK_CODE_CHANGE_EN
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CODE_W-1:0]   shadow_q, shadow_d;
  assign w_code = code_q;
`else
  logic w_unused_set_code;
  assign w_unused_set_code = bus.set_code_i;
  assign w_code = DEFAULT_CODE;
`endif

  always_comb begin
    w_digit = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (bus.key_pulse_i[i]) w_digit = KEY_W'(i);
    end
  end

  assign w_key       = |bus.key_pulse_i;
  assign w_multi     = (bus.key_pulse_i & (bus.key_pulse_i - NUM_KEYS'(1))) != '0;
  // digit_cnt_q counts digits already held, so it selects the slot of the incoming one
  assign w_exp_digit = w_code[(CODE_LEN - 1 - int'(digit_cnt_q)) * KEY_W +: KEY_W];
  assign w_match     = !w_multi && (w_digit == w_exp_digit);
  assign w_last      = (digit_cnt_q == CNT_W'(CODE_LEN - 1));
  assign w_fail_inc  = fail_cnt_q + FAIL_W'(1);

  always_comb begin
    state_d     = state_q;
    digit_cnt_d = digit_cnt_q;
    bad_d       = bad_q;
    fail_cnt_d  = fail_cnt_q;
    tick_cnt_d  = bus.tick_i ? tick_cnt_q + TICK_W'(1) : tick_cnt_q;
    blink_d     = blink_q ^ bus.tick_i;
`ifdef DIGITAL_LOCK_CODE_CHANGE_EN
    code_d      = code_q;
    shadow_d    = shadow_q;
`endif
    case (state_q)
      S_IDLE, S_ENTRY: begin
        if (w_key) begin
          tick_cnt_d = '0;
          if (w_last) begin
            digit_cnt_d = '0;
            bad_d       = 1'b0;
            if (bad_q || !w_match) begin
              fail_cnt_d = w_fail_inc;
              state_d    = (w_fail_inc == FAIL_W'(MAX_FAILS)) ? S_LOCKOUT : S_ERROR;
            end else begin
              fail_cnt_d = '0;
              state_d    = S_UNLOCKED;
            end
          end else begin
            digit_cnt_d = digit_cnt_q + CNT_W'(1);
            bad_d       = bad_q | !w_match;
            state_d     = S_ENTRY;
          end
        end else if (state_q == S_ENTRY && bus.tick_i && tick_cnt_q == ENTRY_LAST) begin
          state_d     = S_IDLE;
          digit_cnt_d = '0;
          bad_d       = 1'b0;
        end
      end
      S_UNLOCKED: begin
        if (bus.lock_req_i) begin
          state_d = S_IDLE;
`ifdef DIGITAL_LOCK_CODE_CHANGE_EN
        end else if (bus.set_code_i) begin
          state_d     = S_SETCODE;
          digit_cnt_d = '0;
          shadow_d    = '0;
`endif
        end else if (UNLOCK_TICKS != 0 && bus.tick_i && tick_cnt_q == UNLOCK_LAST) begin
          state_d = S_IDLE;
        end
      end
      S_ERROR: begin
        if (bus.tick_i && tick_cnt_q == ERR_LAST) state_d = S_IDLE;
      end
      S_LOCKOUT: begin
        if (bus.tick_i && tick_cnt_q == LOCK_LAST) begin
          state_d    = S_IDLE;
          fail_cnt_d = '0;
        end
      end
`ifdef DIGITAL_LOCK_CODE_CHANGE_EN
      S_SETCODE: begin
        if (bus.lock_req_i || (w_key && w_multi)) begin
          state_d     = S_IDLE;
          digit_cnt_d = '0;
        end else if (w_key) begin
          tick_cnt_d = '0;
          shadow_d   = (shadow_q << KEY_W) | CODE_W'(w_digit);
          if (w_last) begin
            code_d      = shadow_d;
            digit_cnt_d = '0;
            state_d     = S_UNLOCKED;
          end else begin
            digit_cnt_d = digit_cnt_q + CNT_W'(1);
          end
        end else if (bus.tick_i && tick_cnt_q == ENTRY_LAST) begin
          state_d     = S_IDLE;
          digit_cnt_d = '0;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) tick_cnt_d = '0;

    // Outputs are decoded from next-state values so they register with the state
    unlocked_d   = (state_d == S_UNLOCKED);
    locked_out_d = (state_d == S_LOCKOUT);
`ifdef DIGITAL_LOCK_CODE_CHANGE_EN
    w_in_entry   = (state_d == S_ENTRY) || (state_d == S_SETCODE);
`else
    w_in_entry   = (state_d == S_ENTRY);
`endif
    for (int i = 0; i < CODE_LEN; i++) begin
      led_d[i] = w_in_entry && (digit_cnt_d > CNT_W'(i));
    end
    case (state_d)
      S_ENTRY:    rgb_d = 3'b001;
      S_UNLOCKED: rgb_d = 3'b010;
      S_ERROR:    rgb_d = 3'b100;
      S_LOCKOUT:  rgb_d = {blink_d, 2'b00};
`ifdef DIGITAL_LOCK_CODE_CHANGE_EN
      S_SETCODE:  rgb_d = {2'b01, blink_d};
`endif
      default:    rgb_d = 3'b000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      digit_cnt_q  <= '0;
      bad_q        <= 1'b0;
      fail_cnt_q   <= '0;
      tick_cnt_q   <= '0;
      blink_q      <= 1'b0;
      unlocked_q   <= 1'b0;
      locked_out_q <= 1'b0;
      led_q        <= '0;
      rgb_q        <= '0;
`ifdef DIGITAL_LOCK_CODE_CHANGE_EN
      code_q       <= DEFAULT_CODE;
      shadow_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      digit_cnt_q  <= digit_cnt_d;
      bad_q        <= bad_d;
      fail_cnt_q   <= fail_cnt_d;
      tick_cnt_q   <= tick_cnt_d;
      blink_q      <= blink_d;
      unlocked_q   <= unlocked_d;
      locked_out_q <= locked_out_d;
      led_q        <= led_d;
      rgb_q        <= rgb_d;
`ifdef DIGITAL_LOCK_CODE_CHANGE_EN
      code_q       <= code_d;
      shadow_q     <= shadow_d;
`endif
    end
  end

  assign bus.unlocked_o   = unlocked_q;
  assign bus.locked_out_o = locked_out_q;
  assign bus.fail_cnt_o   = fail_cnt_q;
  assign bus.led_o        = led_q;
  assign bus.rgb_o        = rgb_q;
endmodule
`default_nettype wire

// File: tb/tb_digital_lock_fsm_param.sv
`default_nettype none
// tb_digital_lock_fsm_param: directed + randomized run against a behavioural lock model.
module tb_digital_lock_fsm_param;
  localparam int NUM_KEYS      = 4;
  localparam int CODE_LEN      = 4;
  localparam int KEY_W         = 2;
  localparam int MAX_FAILS     = 3;
  localparam int LOCKOUT_TICKS = 250;
  localparam int ERR_TICKS     = 25;
  localparam int ENTRY_TICKS   = 125;
  localparam int UNLOCK_TICKS  = 250;
  localparam int DEF_CODE      = 'h84;
`ifdef DIGITAL_LOCK_CODE_CHANGE_EN
  localparam bit CHANGE_EN = 1'b1;
`else
  localparam bit CHANGE_EN = 1'b0;
`endif
  localparam int MI = 0, ME = 1, MU = 2, MR = 3, ML = 4, MS = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  digital_lock_fsm_param_if #(.NUM_KEYS(NUM_KEYS), .CODE_LEN(CODE_LEN), .MAX_FAILS(MAX_FAILS)) bus ();

  digital_lock_fsm_param #(
    .NUM_KEYS(NUM_KEYS), .CODE_LEN(CODE_LEN), .DEFAULT_CODE(8'h84), .MAX_FAILS(MAX_FAILS),
    .LOCKOUT_TICKS(LOCKOUT_TICKS), .ERR_TICKS(ERR_TICKS), .ENTRY_TICKS(ENTRY_TICKS),
    .UNLOCK_TICKS(UNLOCK_TICKS)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Model: mode, entered digits (-1 = multi-key), ticks remaining, fails, blink, code
  int m_mode = MI;
  int m_left = 0;
  int m_fails = 0;
  bit m_blink = 1'b0;
  int m_code = DEF_CODE;
  int m_dig[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int code_digit(input int k);
    return (m_code >> ((CODE_LEN - 1 - k) * KEY_W)) & ((1 << KEY_W) - 1);
  endfunction

  function automatic logic [2:0] exp_rgb();
    case (m_mode)
      ME:      return 3'b001;
      MU:      return 3'b010;
      MR:      return 3'b100;
      ML:      return {m_blink, 2'b00};
      MS:      return {2'b01, m_blink};
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [3:0] exp_led();
    if (m_mode == ME || m_mode == MS) return 4'((1 << m_dig.size()) - 1);
    return 4'b0000;
  endfunction

  task automatic model_reset();
    m_mode = MI; m_left = 0; m_fails = 0; m_blink = 1'b0; m_code = DEF_CODE;
    m_dig.delete();
  endtask

  task automatic judge();
    bit ok;
    ok = 1'b1;
    for (int k = 0; k < CODE_LEN; k++) if (m_dig[k] != code_digit(k)) ok = 1'b0;
    m_dig.delete();
    if (ok) begin
      m_mode = MU; m_fails = 0; m_left = UNLOCK_TICKS;
    end else begin
      m_fails++;
      if (m_fails == MAX_FAILS) begin m_mode = ML; m_left = LOCKOUT_TICKS; end
      else begin m_mode = MR; m_left = ERR_TICKS; end
    end
  endtask

  task automatic model_step(input logic [3:0] k, input bit t, input bit lr, input bit sc);
    bit ev, multi;
    int d;
    ev = (k != 4'b0);
    multi = ($countones(k) > 1);
    d = 0;
    for (int i = 0; i < NUM_KEYS; i++) if (k[i]) d = i;
    if (t) m_blink = !m_blink;
    case (m_mode)
      MI, ME: begin
        if (ev) begin
          m_dig.push_back(multi ? -1 : d);
          m_left = ENTRY_TICKS;
          if (m_dig.size() == CODE_LEN) judge(); else m_mode = ME;
        end else if (m_mode == ME && t) begin
          m_left--;
          if (m_left == 0) begin m_mode = MI; m_dig.delete(); end
        end
      end
      MU: begin
        if (lr) m_mode = MI;
        else if (sc && CHANGE_EN) begin m_mode = MS; m_dig.delete(); m_left = ENTRY_TICKS; end
        else if (t && UNLOCK_TICKS != 0) begin
          m_left--;
          if (m_left == 0) m_mode = MI;
        end
      end
      MR: if (t) begin m_left--; if (m_left == 0) m_mode = MI; end
      ML: if (t) begin m_left--; if (m_left == 0) begin m_mode = MI; m_fails = 0; end end
      MS: begin
        if (lr || (ev && multi)) begin
          m_mode = MI; m_dig.delete();
        end else if (ev) begin
          m_dig.push_back(d);
          m_left = ENTRY_TICKS;
          if (m_dig.size() == CODE_LEN) begin
            m_code = 0;
            foreach (m_dig[i]) m_code = (m_code << KEY_W) | m_dig[i];
            m_dig.delete();
            m_mode = MU; m_left = UNLOCK_TICKS;
          end
        end else if (t) begin
          m_left--;
          if (m_left == 0) begin m_mode = MI; m_dig.delete(); end
        end
      end
      default: m_mode = MI;
    endcase
  endtask

  always @(posedge clk) begin
    #2;
    chk("unlocked", 32'(bus.unlocked_o), 32'(m_mode == MU));
    chk("locked_out", 32'(bus.locked_out_o), 32'(m_mode == ML));
    chk("fail_cnt", 32'(bus.fail_cnt_o), 32'(m_fails));
    chk("led", 32'(bus.led_o), 32'(exp_led()));
    chk("rgb", 32'(bus.rgb_o), 32'(exp_rgb()));
  end

  task automatic cyc(input logic [3:0] k, input bit t, input bit lr, input bit sc);
    bus.key_pulse_i = k; bus.tick_i = t; bus.lock_req_i = lr; bus.set_code_i = sc;
    @(posedge clk);
    if (rst_n) model_step(k, t, lr, sc); else model_reset();
    @(negedge clk);
  endtask

  task automatic press(input int d);
    cyc(4'(1 << d), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic enter(input int a, input int b, input int c, input int d);
    press(a); press(b); press(c); press(d);
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(4'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_unlocked", 32'(bus.unlocked_o), 32'd0);
    chk("rst_led", 32'(bus.led_o), 32'd0);
    chk("rst_rgb", 32'(bus.rgb_o), 32'd0);
    chk("rst_fail", 32'(bus.fail_cnt_o), 32'd0);
    cyc(4'b0, 1'b0, 1'b0, 1'b0);
    cyc(4'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] k;
    bus.key_pulse_i = '0; bus.tick_i = 1'b0; bus.lock_req_i = 1'b0; bus.set_code_i = 1'b0;
    @(negedge clk);
    apply_reset();
    chk("rst_locked_out", 32'(bus.locked_out_o), 32'd0);

    press(2);            chk("led_one", 32'(bus.led_o), 32'h1);
    press(0);            chk("led_two", 32'(bus.led_o), 32'h3);
    press(1);            chk("led_three", 32'(bus.led_o), 32'h7);
    press(0);            chk("t1_unlocked", 32'(bus.unlocked_o), 32'd1);
    chk("t1_rgb", 32'(bus.rgb_o), 32'h2);
    cyc(4'b0, 1'b0, 1'b1, 1'b0);
    chk("t1_relock", 32'(bus.unlocked_o), 32'd0);

    enter(2, 0, 1, 1);
    chk("t2_rgb", 32'(bus.rgb_o), 32'h4);
    chk("t2_fail", 32'(bus.fail_cnt_o), 32'd1);
    ticks(24);           chk("t2_err_hold", 32'(bus.rgb_o), 32'h4);
    ticks(1);            chk("t2_err_done", 32'(bus.rgb_o), 32'h0);

    enter(3, 3, 3, 3);   ticks(25);
    enter(0, 0, 0, 0);
    chk("t3_locked", 32'(bus.locked_out_o), 32'd1);
    chk("t3_fail", 32'(bus.fail_cnt_o), 32'd3);
    chk("t3_blink0", 32'(bus.rgb_o), 32'h0);
    ticks(1);            chk("t3_blink1", 32'(bus.rgb_o), 32'h4);
    enter(2, 0, 1, 0);
    chk("t3_ignored", 32'(bus.unlocked_o), 32'd0);
    ticks(248);          chk("t3_hold", 32'(bus.locked_out_o), 32'd1);
    ticks(1);            chk("t3_release", 32'(bus.locked_out_o), 32'd0);
    chk("t3_fail_clr", 32'(bus.fail_cnt_o), 32'd0);

    enter(1, 1, 1, 1);   ticks(25);
    press(2); press(0);
    ticks(124);          chk("t4_led_hold", 32'(bus.led_o), 32'h3);
    ticks(1);            chk("t4_led_drop", 32'(bus.led_o), 32'h0);
    chk("t4_fail_keep", 32'(bus.fail_cnt_o), 32'd1);
    press(2); cyc(4'b0011, 1'b0, 1'b0, 1'b0); press(1); press(0);
    chk("t4_multi_rgb", 32'(bus.rgb_o), 32'h4);
    chk("t4_multi_fail", 32'(bus.fail_cnt_o), 32'd2);
    ticks(25);
    enter(2, 0, 1, 0);   chk("t4_unlock_fail", 32'(bus.fail_cnt_o), 32'd0);

    ticks(249);          chk("t5_auto_hold", 32'(bus.unlocked_o), 32'd1);
    ticks(1);            chk("t5_auto_relock", 32'(bus.unlocked_o), 32'd0);
    enter(2, 0, 1, 0);
    cyc(4'b0, 1'b0, 1'b1, 1'b0);
    chk("t5_lock_req", 32'(bus.unlocked_o), 32'd0);
    press(2); press(0);
    apply_reset();

    enter(2, 0, 1, 0);
    cyc(4'b0, 1'b0, 1'b0, 1'b1);
    if (CHANGE_EN) begin
      chk("t6_setcode_rgb", 32'(bus.rgb_o), 32'h2);
      chk("t6_setcode_unl", 32'(bus.unlocked_o), 32'd0);
      enter(3, 3, 1, 0);   chk("t6_new_stored", 32'(bus.unlocked_o), 32'd1);
      cyc(4'b0, 1'b0, 1'b1, 1'b0);
      enter(3, 3, 1, 0);   chk("t6_new_unlocks", 32'(bus.unlocked_o), 32'd1);
      cyc(4'b0, 1'b0, 1'b1, 1'b0);
      enter(2, 0, 1, 0);   chk("t6_old_fails", 32'(bus.fail_cnt_o), 32'd1);
    end else begin
      chk("t6_ignored", 32'(bus.unlocked_o), 32'd1);
      cyc(4'b0, 1'b0, 1'b1, 1'b0);
      enter(2, 0, 1, 0);   chk("t6_default_kept", 32'(bus.unlocked_o), 32'd1);
    end
    apply_reset();

    for (int n = 0; n < 6000; n++) begin
      k = 4'b0;
      if ($urandom_range(0, 99) < 35) begin
        if ($urandom_range(0, 99) < 8) k = 4'($urandom_range(0, 15));
        else if ((m_mode == MI || m_mode == ME) && $urandom_range(0, 3) != 0)
          k = 4'(1 << code_digit(m_dig.size()));
        else k = 4'(1 << $urandom_range(0, 3));
      end
      if ($urandom_range(0, 999) == 0) apply_reset();
      else cyc(k, $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 3,
               $urandom_range(0, 99) < 4);
    end
    cyc(4'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
